switch_debounce: RTL and testbench
==================================

// Module: switch_debounce
// PURPOSE
//  Conditions the four raw push-button/slide-switch inputs before they reach the 2-bit adder operand inputs.
//  Per bit: two-flop synchroniser, then a stability counter. Publishes clean levels, a one-cycle change strobe
//  and per-bit press (rising-edge) pulses. Sits directly upstream of the adder: sw_clean[1:0] -> op_1, sw_clean[3:2] -> op_2.
// PARAMETERS
//  NUM_SW          4        number of switch inputs debounced in parallel (>=1)
//  DEBOUNCE_LIMIT  250000   consecutive cycles a synchronised level must hold before acceptance (>=2; 10 ms @ 25 MHz)
//  CNT_W           $clog2(DEBOUNCE_LIMIT)  per-bit counter width (localparam, not overridable)
// PORTS
//  clk        in   1       system clock, all logic on rising edge
//  rst_n      in   1       asynchronous active-low reset
//  sw_raw     in   NUM_SW  raw asynchronous switch levels, bit0 = sw1
//  sw_clean   out  NUM_SW  debounced level, registered
//  sw_changed out  1       1-cycle pulse: at least one sw_clean bit updated this cycle
//  sw_press   out  NUM_SW  1-cycle per-bit pulse on accepted 0->1 transition (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async assert, sync-safe release): sync flops, counters, sw_clean, sw_changed, sw_press all 0.
//  Synchroniser: s1 <= sw_raw; s2 <= s1. s2 is the only input to the filter; sw_raw is never used elsewhere.
//  Per-bit filter, evaluated every edge:
//   - s2 == sw_clean[i]          : cnt[i] <= 0.
//   - s2 != clean, cnt < LIMIT-1 : cnt[i] <= cnt[i]+1.
//   - s2 != clean, cnt == LIMIT-1: sw_clean[i] <= s2; cnt[i] <= 0.
//  Latency: raw level held steady ahead of edge k -> sw_clean updates at edge k+DEBOUNCE_LIMIT+1,
//   i.e. visible DEBOUNCE_LIMIT+2 edges after the first sampling edge.
//  Glitch rejection: any return of s2 to the clean value before LIMIT consecutive mismatches clears cnt;
//   no output change and the next mismatch restarts at count 1.
//  Counter never exceeds LIMIT-1; no wrap-around possible.
//  Bits are fully independent: simultaneous changes on several bits each run their own counter.
//   Bits maturing on the same edge update together with a single sw_changed pulse.
//  sw_changed: registered, high for exactly the cycle following the edge on which any sw_clean bit updated
//   (coincident with new sw_clean value visible).
//  sw_press[i]: high for one cycle, same cycle as sw_changed, when sw_clean[i] went 0->1. Never on 1->0.
//  Reset mid-count: counters discarded. After release, all clean outputs restart at 0; switches already held
//   high are re-accepted after the full latency and produce press pulses.
//  No combinational path from any input to any output.
// CONFIGURATION
//  Macro SWITCH_DEBOUNCE_PRESS_EN.
//   Defined     : sw_press generated as above (edge-detect register on sw_clean).
//   Not defined : sw_press tied to all-zero; edge-detect logic not built. Port list unchanged.
//   sw_clean and sw_changed are unaffected either way.
// TESTING (bench uses DEBOUNCE_LIMIT=4, NUM_SW=4)
//  1. Reset: rst_n=0 with sw_raw=4'hF -> all outputs 0 immediately (async), stay 0 while held.
//  2. Clean step: sw_raw 0->4'b0001 held -> sw_clean=4'b0001 after exactly 6 edges;
//     sw_changed=1 and sw_press=4'b0001 for 1 cycle; no further pulses.
//  3. Bounce: bit1 toggles 1,0,1,0 every 2 cycles, then held 1 -> no sw_clean change during bounce;
//     sw_clean[1]=1 exactly 6 edges after final rise.
//  4. Simultaneous: bits 2,3 rise on same edge -> sw_clean=4'b1100 same cycle, single sw_changed pulse,
//     sw_press=4'b1100.
//  5. Release: bit0 1->0 held -> sw_clean[0]=0 after 6 edges; sw_changed=1; sw_press=0.
//  6. Reset mid-count: rst_n pulsed low 2 cycles after a rise -> outputs 0;
//     new 6-edge latency measured from release.
//     Repeat 2 with macro undefined -> sw_press stays 4'h0.

Source files
------------

// File: rtl/switch_debounce.sv
// rtl/switch_debounce.sv - per-bit two-flop synchroniser plus stability-counter debounce filter
// Optional press pulses are built only when SWITCH_DEBOUNCE_PRESS_EN is defined.
module switch_debounce #(
    parameter int NUM_SW         = 4,
    parameter int DEBOUNCE_LIMIT = 250000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_SW-1:0] sw_raw,
    output logic [NUM_SW-1:0] sw_clean,
    output logic              sw_changed,
    output logic [NUM_SW-1:0] sw_press
);

    localparam int CNT_W = $clog2(DEBOUNCE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_LIMIT - 1);

    logic [NUM_SW-1:0] r_sync1;
    logic [NUM_SW-1:0] r_sync2;
    logic [NUM_SW-1:0] r_clean;
    logic              r_changed;
    logic [CNT_W-1:0]  r_cnt [NUM_SW];
    logic [NUM_SW-1:0] w_mismatch;
    logic [NUM_SW-1:0] w_mature;

    // A bit matures when the synchronised level has disagreed with the clean level for LIMIT edges.
    always_comb begin
        w_mismatch = r_sync2 ^ r_clean;
        w_mature   = '0;
        for (int i = 0; i < NUM_SW; i++) begin
            w_mature[i] = w_mismatch[i] && (r_cnt[i] == CNT_MAX);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= sw_raw;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SW; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SW; i++) begin
                if (!w_mismatch[i] || w_mature[i]) begin
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clean   <= '0;
            r_changed <= 1'b0;
        end else begin
            r_clean   <= r_clean ^ w_mature;
            r_changed <= |w_mature;
        end
    end

    assign sw_clean   = r_clean;
    assign sw_changed = r_changed;

`ifdef SWITCH_DEBOUNCE_PRESS_EN
    logic [NUM_SW-1:0] r_press;

    // Maturing bits whose new level is 1 are exactly the accepted 0->1 transitions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_press <= '0;
        end else begin
            r_press <= w_mature & r_sync2;
        end
    end

    assign sw_press = r_press;
`else
    assign sw_press = '0;
`endif

endmodule

// File: tb/tb_switch_debounce.sv
// tb/tb_switch_debounce.sv - scoreboard bench for switch_debounce with DEBOUNCE_LIMIT=4, NUM_SW=4
module tb_switch_debounce;

`ifdef SWITCH_DEBOUNCE_PRESS_EN
    localparam bit PRESS_EN = 1'b1;
`else
    localparam bit PRESS_EN = 1'b0;
`endif
    localparam int LAT = 6;

    logic       clk;
    logic       rst_n;
    logic [3:0] sw_raw;
    logic [3:0] sw_clean;
    logic       sw_changed;
    logic [3:0] sw_press;

    typedef struct {
        int         cyc;
        logic [3:0] clean;
        logic [3:0] press;
    } exp_t;

    exp_t       q[$];
    int         cyc = 0;
    int         passed = 0;
    int         total = 0;
    logic [3:0] model_clean = 4'h0;

    switch_debounce #(
        .NUM_SW(4),
        .DEBOUNCE_LIMIT(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .sw_raw(sw_raw),
        .sw_clean(sw_clean),
        .sw_changed(sw_changed),
        .sw_press(sw_press)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push_exp(input logic [3:0] clean, input logic [3:0] press);
        exp_t e;
        e.cyc   = cyc + LAT;
        e.clean = clean;
        e.press = PRESS_EN ? press : 4'h0;
        q.push_back(e);
    endtask

    task automatic wc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string name);
        total++;
        if (sw_clean !== 4'h0 || sw_changed !== 1'b0 || sw_press !== 4'h0)
            $display("FAIL %s: clean=%h changed=%b press=%h, required all 0", name, sw_clean, sw_changed, sw_press);
        else
            passed++;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            model_clean = 4'h0;
            check_zero("reset_hold");
        end else if (sw_changed) begin
            total++;
            if (q.size() == 0) begin
                $display("FAIL unexpected_pulse: cyc=%0d clean=%h press=%h, required no pulse", cyc, sw_clean, sw_press);
            end else begin
                e = q.pop_front();
                model_clean = e.clean;
                if (e.cyc != cyc || e.clean !== sw_clean || e.press !== sw_press)
                    $display("FAIL pulse: cyc=%0d clean=%h press=%h, required cyc=%0d clean=%h press=%h",
                             cyc, sw_clean, sw_press, e.cyc, e.clean, e.press);
                else
                    passed++;
            end
        end else begin
            total++;
            if (sw_clean !== model_clean || sw_press !== 4'h0)
                $display("FAIL idle: cyc=%0d clean=%h press=%h, required clean=%h press=0",
                         cyc, sw_clean, sw_press, model_clean);
            else
                passed++;
        end
    end

    initial begin
        rst_n  = 1'b0;
        sw_raw = 4'hF;
        #1;
        check_zero("reset_async");
        wc(3);
        sw_raw = 4'h0;
        rst_n  = 1'b1;
        wc(3);

        // clean step on bit0
        sw_raw = 4'b0001;
        push_exp(4'b0001, 4'b0001);
        wc(12);

        // bit1 bounces with runs shorter than the limit, then settles high
        sw_raw = 4'b0011; wc(2);
        sw_raw = 4'b0001; wc(2);
        sw_raw = 4'b0011; wc(2);
        sw_raw = 4'b0001; wc(2);
        sw_raw = 4'b0011;
        push_exp(4'b0011, 4'b0010);
        wc(12);

        // bits 2 and 3 together
        sw_raw = 4'b1111;
        push_exp(4'b1111, 4'b1100);
        wc(12);

        // release bit0
        sw_raw = 4'b1110;
        push_exp(4'b1110, 4'b0000);
        wc(12);

        // reset mid-count, then everything held high is re-accepted
        sw_raw = 4'b1111;
        wc(2);
        rst_n = 1'b0;
        #1;
        check_zero("reset_midcount");
        wc(2);
        rst_n = 1'b1;
        push_exp(4'b1111, 4'b1111);
        wc(12);

        total++;
        if (q.size() != 0)
            $display("FAIL missing_pulse: %0d expected pulses never seen, required 0", q.size());
        else
            passed++;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
